sdram_req_sched: RTL and testbench
==================================

Name: sdram_req_sched

Overview:
Upstream front end for the SDRAM command state machine. It buffers read/write requests from the sort engine in a small FIFO and owns the auto-refresh interval timer. It presents one command at a time (data or refresh) to the controller over a valid/ready handshake, and refresh always takes priority at the next command boundary.

Parameters:
addr_width_p, 22, request address width (bank+row+column)
data_width_p, 16, write data width
depth_p, 4, FIFO entries; power of two, >= 2
refresh_cycles_p, 1040, clocks between refresh requests (7.8 us at 133 MHz)
max_postpone_p, 8, max outstanding refreshes before overrun error

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
req_valid_i  in  1  sort engine request valid
req_ready_o  out  1  FIFO can accept a request
req_we_i  in  1  1 = write, 0 = read
req_addr_i  in  addr_width_p  request address
req_wdata_i  in  data_width_p  write data (ignored for reads)
cmd_valid_o  out  1  command presented to controller (drives go_i)
cmd_ready_i  in  1  controller accepts command this cycle
cmd_we_o  out  1  write command (drives rw_en_i); 0 for refresh
cmd_refresh_o  out  1  presented command is auto-refresh
cmd_addr_o  out  addr_width_p  command address; 0 for refresh
cmd_wdata_o  out  data_width_p  command write data
refresh_pending_o  out  1  at least one refresh outstanding
count_o  out  $clog2(depth_p)+1  FIFO occupancy
overrun_o  out  1  sticky: refresh postponement limit exceeded

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: all outputs 0 except req_ready_o=1. FIFO empty, pointers 0, timer = refresh_cycles_p-1, pending count 0, state IDLE.
- Reset mid-operation discards queued requests and any presented command, with no completion to the controller.
- FIFO push: happens when req_valid_i & req_ready_o. req_ready_o = (count != depth_p). It depends only on occupancy; a same-cycle pop does not enable a push when full.
- FIFO pop: happens on acceptance (cmd_valid_o & cmd_ready_i) of a data command. Pointers wrap modulo depth_p.
- Simultaneous push and pop when not full leaves count unchanged.
- Refresh timer:
  - Decrements every cycle.
  - At 0 it reloads refresh_cycles_p-1 and increments the pending count. The count saturates at max_postpone_p.
  - An increment attempted at saturation sets overrun_o, which clears only on reset.
  - Accepting a refresh command decrements the pending count. Same-cycle expiry and acceptance leave the count unchanged.
- refresh_pending_o = (pending count != 0).
- State machine (registered state). Command outputs decode from state plus FIFO head.
  - IDLE: cmd_valid_o=0. Next state is PRES_REF if refresh pending, else PRES_REQ if FIFO non-empty, else IDLE.
  - PRES_REQ: cmd_valid_o=1, cmd_refresh_o=0; cmd_we_o/addr/wdata come from the FIFO head and are held stable until accepted.
  - PRES_REQ on accept: go to PRES_REF if refresh pending (including pending set this cycle), else PRES_REQ if entries remain after the pop, else IDLE. A refresh arriving mid-presentation never preempts the held data command.
  - PRES_REF: cmd_valid_o=1, cmd_refresh_o=1, cmd_we_o=0, cmd_addr_o=0, cmd_wdata_o=0.
  - PRES_REF on accept: go to PRES_REF if pending remains after the decrement, else PRES_REQ if FIFO non-empty, else IDLE.
- Latency: a request pushed into an empty FIFO while in IDLE with no refresh pending appears on cmd_valid_o the next cycle (1-cycle latency).
- Back-to-back: consecutive accepts issue one command per cycle with no idle bubble.
- cmd_valid_o never deasserts without acceptance, except on reset.

Test Plan:
- Single write: push we=1, addr=0x00123, wdata=0xBEEF into empty FIFO at cycle N, cmd_ready_i=1 -> cmd_valid_o=1 at N+1 with those values; count_o returns to 0 at N+2.
- Fill and backpressure: cmd_ready_i=0, push 5 requests -> first 4 accepted, req_ready_o=0 while count_o=4; the 5th is held. Raise cmd_ready_i -> 4 commands issue in FIFO order, one per cycle.
- Refresh priority: refresh_cycles_p=16, FIFO holds 2 reads, and timer expiry occurs while read 0 is presented but unaccepted -> read 0 stays stable until accepted, then refresh (cmd_refresh_o=1, cmd_we_o=0), then read 1.
- Postponement overrun: max_postpone_p=8, cmd_ready_i=0 for 9 refresh intervals -> pending saturates at 8 and overrun_o=1. Then release ready -> 8 refresh commands issue, and refresh_pending_o=0 afterwards.
- Simultaneous expiry and accept: timer hits 0 in the same cycle a refresh is accepted with pending=1 -> pending stays 1 and another refresh is presented the next cycle.
- Reset mid-operation: 3 queued, one presented, assert rst_i one cycle -> next cycle cmd_valid_o=0, count_o=0, req_ready_o=1, overrun_o=0, and the timer restarts from refresh_cycles_p-1.

Source files
------------

// File: rtl/sdram_req_sched.sv
// Request FIFO, refresh interval timer and command presenter
// sitting in front of the SDRAM command state machine.
module sdram_req_sched #(
    parameter int addr_width_p     = 22,
    parameter int data_width_p     = 16,
    parameter int depth_p          = 4,
    parameter int refresh_cycles_p = 1040,
    parameter int max_postpone_p   = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic                       req_we_i,
    input  logic [addr_width_p-1:0]    req_addr_i,
    input  logic [data_width_p-1:0]    req_wdata_i,
    output logic                       cmd_valid_o,
    input  logic                       cmd_ready_i,
    output logic                       cmd_we_o,
    output logic                       cmd_refresh_o,
    output logic [addr_width_p-1:0]    cmd_addr_o,
    output logic [data_width_p-1:0]    cmd_wdata_o,
    output logic                       refresh_pending_o,
    output logic [$clog2(depth_p):0]   count_o,
    output logic                       overrun_o
);

    localparam int PtrW  = $clog2(depth_p);
    localparam int CntW  = PtrW + 1;
    localparam int TmrW  = $clog2(refresh_cycles_p);
    localparam int PendW = $clog2(max_postpone_p + 1);

    typedef enum logic [1:0] {
        IDLE,
        PRES_REQ,
        PRES_REF
    } state_e;

    logic                    we_mem    [depth_p];
    logic [addr_width_p-1:0] addr_mem  [depth_p];
    logic [data_width_p-1:0] wdata_mem [depth_p];

    state_e            state_q, state_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [TmrW-1:0]   timer_q, timer_d;
    logic [PendW-1:0]  pend_q, pend_d;
    logic              ovr_q, ovr_d;

    logic push, pop, accept, ref_acc, expire;

    assign req_ready_o = (count_q != CntW'(depth_p));
    assign push        = req_valid_i & req_ready_o;
    assign accept      = cmd_valid_o & cmd_ready_i;
    assign pop         = accept & (state_q == PRES_REQ);
    assign ref_acc     = accept & (state_q == PRES_REF);
    assign expire      = (timer_q == '0);

    // Next-state: FIFO bookkeeping, refresh timer/credits, presenter
    always_comb begin
        wr_ptr_d = wr_ptr_q + PtrW'(push);
        rd_ptr_d = rd_ptr_q + PtrW'(pop);
        count_d  = count_q + CntW'(push) - CntW'(pop);
        timer_d  = expire ? TmrW'(refresh_cycles_p - 1)
                          : timer_q - 1'b1;
        pend_d   = pend_q;
        ovr_d    = ovr_q;
        if (expire && !ref_acc) begin
            if (pend_q == PendW'(max_postpone_p)) begin
                ovr_d = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end else if (!expire && ref_acc) begin
            pend_d = pend_q - 1'b1;
        end
        // A held command only moves on when accepted; refresh wins
        // every boundary, so a late refresh never preempts held data.
        state_d = state_q;
        if (state_q == IDLE || accept) begin
            if (pend_d != '0) begin
                state_d = PRES_REF;
            end else if (count_d != '0) begin
                state_d = PRES_REQ;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // Control registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            timer_q  <= TmrW'(refresh_cycles_p - 1);
            pend_q   <= '0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            timer_q  <= timer_d;
            pend_q   <= pend_d;
            ovr_q    <= ovr_d;
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk_i) begin
        if (push) begin
            we_mem[wr_ptr_q]    <= req_we_i;
            addr_mem[wr_ptr_q]  <= req_addr_i;
            wdata_mem[wr_ptr_q] <= req_wdata_i;
        end
    end

    logic is_req;
    assign is_req = (state_q == PRES_REQ);

    assign cmd_valid_o       = (state_q != IDLE);
    assign cmd_refresh_o     = (state_q == PRES_REF);
    assign cmd_we_o          = is_req & we_mem[rd_ptr_q];
    assign cmd_addr_o        = is_req ? addr_mem[rd_ptr_q] : '0;
    assign cmd_wdata_o       = is_req ? wdata_mem[rd_ptr_q] : '0;
    assign refresh_pending_o = (pend_q != '0);
    assign count_o           = count_q;
    assign overrun_o         = ovr_q;

endmodule

// File: tb/tb_sdram_req_sched.sv
// Scoreboard bench for sdram_req_sched: queue-level reference model
// predicts presented commands and status; a monitor compares them.
module tb_sdram_req_sched;

    localparam int AW = 22;
    localparam int DW = 16;
    localparam int D  = 4;
    localparam int R  = 16;
    localparam int M  = 8;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic          req_we_i = 1'b0;
    logic [AW-1:0] req_addr_i = '0;
    logic [DW-1:0] req_wdata_i = '0;
    logic          cmd_valid_o;
    logic          cmd_ready_i = 1'b0;
    logic          cmd_we_o;
    logic          cmd_refresh_o;
    logic [AW-1:0] cmd_addr_o;
    logic [DW-1:0] cmd_wdata_o;
    logic          refresh_pending_o;
    logic [CW-1:0] count_o;
    logic          overrun_o;

    sdram_req_sched #(
        .addr_width_p(AW), .data_width_p(DW), .depth_p(D),
        .refresh_cycles_p(R), .max_postpone_p(M)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i),
        .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
        .cmd_we_o(cmd_we_o), .cmd_refresh_o(cmd_refresh_o),
        .cmd_addr_o(cmd_addr_o), .cmd_wdata_o(cmd_wdata_o),
        .refresh_pending_o(refresh_pending_o),
        .count_o(count_o), .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          refr;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    // reference model state
    cmd_t fq[$];
    cmd_t expq[$];
    int   m_pend;
    int   m_timer;
    bit   m_ovr;
    int   m_pres;      // 0 nothing, 1 data, 2 refresh
    bit   m_on = 1'b0;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: advances on each clock using the applied inputs
    always @(posedge clk) begin
        if (rst_i) begin
            fq.delete();
            expq.delete();
            m_pend  = 0;
            m_timer = R - 1;
            m_ovr   = 1'b0;
            m_pres  = 0;
            m_on    = 1'b1;
        end else if (m_on) begin
            bit acc, expire, can_push, racc;
            acc      = (m_pres != 0) && cmd_ready_i;
            racc     = acc && (m_pres == 2);
            can_push = fq.size() < D;
            expire   = (m_timer == 0);
            m_timer  = expire ? R - 1 : m_timer - 1;
            if (acc && m_pres == 1) void'(fq.pop_front());
            if (req_valid_i && can_push)
                fq.push_back(cmd_t'{refr: 1'b0, we: req_we_i,
                             addr: req_addr_i, wdata: req_wdata_i});
            if (expire && !racc) begin
                if (m_pend == M) m_ovr = 1'b1;
                else m_pend++;
            end else if (!expire && racc) begin
                m_pend--;
            end
            if (m_pres == 0 || acc) begin
                if (m_pend > 0) begin
                    m_pres = 2;
                    expq.push_back(cmd_t'{refr: 1'b1, default: '0});
                end else if (fq.size() > 0) begin
                    m_pres = 1;
                    expq.push_back(fq[0]);
                end else begin
                    m_pres = 0;
                end
            end
        end
    end

    // Monitor: compares status every cycle, pops on handshake
    always @(negedge clk) begin
        if (m_on) begin
            chk("cmd_valid", 64'(cmd_valid_o), 64'(m_pres != 0));
            chk("count", 64'(count_o), 64'(fq.size()));
            chk("req_ready", 64'(req_ready_o), 64'(fq.size() < D));
            chk("ref_pending", 64'(refresh_pending_o), 64'(m_pend != 0));
            chk("overrun", 64'(overrun_o), 64'(m_ovr));
            if (cmd_valid_o) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cmd: got valid expected none at %0t",
                             $time);
                end else begin
                    chk("cmd_refresh", 64'(cmd_refresh_o), 64'(expq[0].refr));
                    chk("cmd_we", 64'(cmd_we_o), 64'(expq[0].we));
                    chk("cmd_addr", 64'(cmd_addr_o), 64'(expq[0].addr));
                    chk("cmd_wdata", 64'(cmd_wdata_o), 64'(expq[0].wdata));
                    if (cmd_ready_i) void'(expq.pop_front());
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
        int n;
        n = 0;
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = a;
        req_wdata_i = d;
        @(negedge clk);
        while (!req_ready_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready_o) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got ready=0 expected ready=1");
        end
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        while (!(m_pend == 0 && fq.size() == 0 && m_pres == 0
                 && m_timer > 6) && n < 200) begin
            step(1);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL quiet_timeout: got busy expected idle");
        end
    endtask

    initial begin
        int n;
        step(3);
        rst_i = 1'b0;
        cmd_ready_i = 1'b1;

        // single write, one-cycle latency
        send(1'b1, 22'h00123, 16'hBEEF);
        @(negedge clk);
        chk("lat_valid", 64'(cmd_valid_o), 64'd1);
        chk("lat_addr", 64'(cmd_addr_o), 64'h123);
        chk("lat_wdata", 64'(cmd_wdata_o), 64'hBEEF);
        chk("lat_we", 64'(cmd_we_o), 64'd1);
        @(negedge clk);
        chk("lat_count", 64'(count_o), 64'd0);
        step(2);

        // fill and backpressure
        cmd_ready_i = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send(i[0], AW'(22'h1000 + i), DW'(16'hA000 + i));
            end
            begin
                step(8);
                @(negedge clk);
                chk("full_count", 64'(count_o), 64'd4);
                chk("full_ready", 64'(req_ready_o), 64'd0);
                step(4);
                cmd_ready_i = 1'b1;
            end
        join
        step(12);

        // refresh arriving while read 0 is held
        wait_quiet();
        cmd_ready_i = 1'b0;
        send(1'b0, 22'h2A0, 16'h0);
        send(1'b0, 22'h2A1, 16'h0);
        step(20);
        @(negedge clk);
        chk("held_addr", 64'(cmd_addr_o), 64'h2A0);
        chk("held_pending", 64'(refresh_pending_o), 64'd1);
        step(1);
        cmd_ready_i = 1'b1;
        step(10);

        // reset with requests queued and one presented
        cmd_ready_i = 1'b0;
        for (int i = 0; i < 4; i++)
            send(1'b1, AW'(22'h3000 + i), DW'(16'h5500 + i));
        rst_i = 1'b1;
        step(1);
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_valid", 64'(cmd_valid_o), 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_ready", 64'(req_ready_o), 64'd1);
        chk("rst_overrun", 64'(overrun_o), 64'd0);

        // refresh accepted in the same cycle the timer expires
        n = 0;
        while (!(m_timer == 0 && m_pres == 2 && m_pend == 1) && n < 100) begin
            step(1);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL align_timeout: got no alignment expected one");
        end
        cmd_ready_i = 1'b1;
        step(1);
        cmd_ready_i = 1'b0;
        @(negedge clk);
        chk("sim_pending", 64'(refresh_pending_o), 64'd1);
        chk("sim_refresh", 64'(cmd_refresh_o), 64'd1);
        step(1);

        // postponement overrun
        step(9 * R + 4);
        @(negedge clk);
        chk("ovr_flag", 64'(overrun_o), 64'd1);
        step(1);
        cmd_ready_i = 1'b1;
        step(12);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            req_valid_i = 1'($urandom_range(0, 1));
            req_we_i    = 1'($urandom_range(0, 1));
            req_addr_i  = AW'($urandom);
            req_wdata_i = DW'($urandom);
            cmd_ready_i = ($urandom_range(0, 3) != 0);
            if (i % 150 == 149) cmd_ready_i = 1'b0;
            step(1);
        end
        req_valid_i = 1'b0;
        cmd_ready_i = 1'b1;
        step(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
